// File: rtl/phy_tx_serializer.sv
// Byte-to-serial transmitter for the PHY link.
// After reset it sends SYNC_SYMS comma symbols (0xBC). It then sends buffered
// bytes MSB first, or an idle comma when the buffer is empty. A small FIFO
// decouples the byte producer from the 8-cycle symbol cadence.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_SYNC | sending the post-reset comma train; bytes are buffered only
//   ST_RUN  | each symbol is the FIFO head if one is present, else idle comma
module phy_tx_serializer #(
    parameter int SYNC_SYMS  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       data_out,
    output logic       sym_start,
    output logic       data_flag,
    output logic       active
);

    localparam int PTR_W  = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int SYNC_W = (SYNC_SYMS < 1) ? 1 : $clog2(SYNC_SYMS + 1);
    localparam logic [7:0] COMMA = 8'hBC;

    typedef enum logic {ST_SYNC, ST_RUN} state_t;

    state_t             state_q, state_d;
    logic [SYNC_W-1:0]  sync_left_q, sync_left_d;
    logic [2:0]         bits_left_q, bits_left_d;
    logic [6:0]         shift_q, shift_d;
    logic               data_out_q, data_out_d;
    logic               sym_start_q, sym_start_d;
    logic               data_flag_q, data_flag_d;
    logic               active_q, active_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [7:0]         mem_q [FIFO_DEPTH];

    logic       boundary;
    logic       run_rules;
    logic       push;
    logic       pop;
    logic [7:0] sym;

    // Handshake and symbol-boundary decode. bits_left_q is cleared by reset,
    // which makes the first edge after release a boundary.
    always_comb begin
        ready_out = reset && (count_q < CNT_W'(FIFO_DEPTH));
        boundary  = (bits_left_q == 3'd0);
        // The symbol that ends the comma train is already chosen as in RUN.
        run_rules = (state_q == ST_RUN) || (sync_left_q == '0);
        push      = valid_in && ready_out;
        pop       = boundary && run_rules && (count_q != '0);
    end

    // Next-state: symbol selection, serializer shift, FSM and FIFO bookkeeping.
    always_comb begin
        state_d     = state_q;
        sync_left_d = sync_left_q;
        bits_left_d = bits_left_q - 3'd1;
        shift_d     = {shift_q[5:0], 1'b0};
        data_out_d  = shift_q[6];
        sym_start_d = 1'b0;
        data_flag_d = data_flag_q;
        active_d    = active_q;
        sym         = COMMA;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        if (boundary) begin
            bits_left_d = 3'd7;
            if (state_q == ST_SYNC) begin
                if (sync_left_q == '0) begin
                    state_d  = ST_RUN;
                    active_d = 1'b1;
                end else begin
                    sync_left_d = sync_left_q - SYNC_W'(1);
                end
            end
            if (pop) begin
                sym = mem_q[rd_ptr_q];
            end
            data_flag_d = pop;
            data_out_d  = sym[7];
            shift_d     = sym[6:0];
            sym_start_d = 1'b1;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            state_q     <= ST_SYNC;
            sync_left_q <= SYNC_W'(SYNC_SYMS);
            bits_left_q <= 3'd0;
            shift_q     <= '0;
            data_out_q  <= 1'b0;
            sym_start_q <= 1'b0;
            data_flag_q <= 1'b0;
            active_q    <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            sync_left_q <= sync_left_d;
            bits_left_q <= bits_left_d;
            shift_q     <= shift_d;
            data_out_q  <= data_out_d;
            sym_start_q <= sym_start_d;
            data_flag_q <= data_flag_d;
            active_q    <= active_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // FIFO storage; contents need no reset because the pointers and count do.
    always_ff @(posedge clk_32f) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign data_out  = data_out_q;
    assign sym_start = sym_start_q;
    assign data_flag = data_flag_q;
    assign active    = active_q;

endmodule

// File: tb/tb_phy_tx_serializer.sv
// Directed bench for phy_tx_serializer: symbol-level vector tables and
// hand-written sequences for FIFO-full and mid-symbol reset cases.
module tb_phy_tx_serializer;

    logic       clk_32f = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic       data_out;
    logic       sym_start;
    logic       data_flag;
    logic       active;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        int         pf;
        int         pt;
        logic [7:0] din;
        logic [7:0] sym;
        logic       flag;
        logic       act;
        logic       rdy;
    } vec_t;

    vec_t tab_a [9];
    vec_t tab_b [6];
    vec_t tab_c [6];

    phy_tx_serializer #(.SYNC_SYMS(4), .FIFO_DEPTH(4)) dut (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .data_in  (data_in),
        .valid_in (valid_in),
        .ready_out(ready_out),
        .data_out (data_out),
        .sym_start(sym_start),
        .data_flag(data_flag),
        .active   (active)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic chk(input string name, input logic [7:0] act_v, input logic [7:0] exp_v);
        nvec++;
        if (act_v !== exp_v) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act_v, exp_v, $time);
        end
    endtask

    task automatic edge_step();
        @(posedge clk_32f);
        #1;
    endtask

    // One reset edge: every registered output and ready_out must be low.
    task automatic reset_edge();
        reset    = 1'b0;
        valid_in = 1'b1;
        data_in  = 8'h5A;
        edge_step();
        chk("rst_data_out", {7'd0, data_out}, 8'd0);
        chk("rst_sym_start", {7'd0, sym_start}, 8'd0);
        chk("rst_data_flag", {7'd0, data_flag}, 8'd0);
        chk("rst_active", {7'd0, active}, 8'd0);
        chk("rst_ready", {7'd0, ready_out}, 8'd0);
    endtask

    // Run one 8-cycle symbol, optionally pushing din on cycles pf..pt.
    task automatic run_sym(input vec_t v);
        for (int i = 0; i < 8; i++) begin
            valid_in = (i >= v.pf) && (i <= v.pt);
            data_in  = v.din;
            edge_step();
            valid_in = 1'b0;
            chk("data_out", {7'd0, data_out}, {7'd0, v.sym[7-i]});
            chk("sym_start", {7'd0, sym_start}, {7'd0, (i == 0)});
            chk("data_flag", {7'd0, data_flag}, {7'd0, v.flag});
            chk("active", {7'd0, active}, {7'd0, v.act});
            if (i == 0) chk("ready_out", {7'd0, ready_out}, {7'd0, v.rdy});
        end
    endtask

    initial begin
        logic [7:0] din_b [8];
        logic       rdy_b [8];
        logic [7:0] comma;
        logic [7:0] d11;

        // Sync train, byte held through SYNC, data 0xBC, push on empty boundary.
        tab_a[0] = '{0,  0, 8'hA5, 8'hBC, 1'b0, 1'b0, 1'b1};
        tab_a[1] = '{-1, -1, 8'h00, 8'hBC, 1'b0, 1'b0, 1'b1};
        tab_a[2] = '{-1, -1, 8'h00, 8'hBC, 1'b0, 1'b0, 1'b1};
        tab_a[3] = '{-1, -1, 8'h00, 8'hBC, 1'b0, 1'b0, 1'b1};
        tab_a[4] = '{0,  0, 8'hBC, 8'hA5, 1'b1, 1'b1, 1'b1};
        tab_a[5] = '{-1, -1, 8'h00, 8'hBC, 1'b1, 1'b1, 1'b1};
        tab_a[6] = '{0,  0, 8'h33, 8'hBC, 1'b0, 1'b1, 1'b1};
        tab_a[7] = '{-1, -1, 8'h00, 8'h33, 1'b1, 1'b1, 1'b1};
        tab_a[8] = '{-1, -1, 8'h00, 8'hBC, 1'b0, 1'b1, 1'b1};
        // Burst drain: 0x05 offered at the full-FIFO boundary, accepted a cycle later.
        tab_b[0] = '{0,  1, 8'h05, 8'h01, 1'b1, 1'b1, 1'b1};
        tab_b[1] = '{-1, -1, 8'h00, 8'h02, 1'b1, 1'b1, 1'b1};
        tab_b[2] = '{-1, -1, 8'h00, 8'h03, 1'b1, 1'b1, 1'b1};
        tab_b[3] = '{-1, -1, 8'h00, 8'h04, 1'b1, 1'b1, 1'b1};
        tab_b[4] = '{-1, -1, 8'h00, 8'h05, 1'b1, 1'b1, 1'b1};
        tab_b[5] = '{-1, -1, 8'h00, 8'hBC, 1'b0, 1'b1, 1'b1};
        // After a mid-symbol reset: fresh comma train, buffered bytes gone.
        tab_c[0] = '{-1, -1, 8'h00, 8'hBC, 1'b0, 1'b0, 1'b1};
        tab_c[1] = '{-1, -1, 8'h00, 8'hBC, 1'b0, 1'b0, 1'b1};
        tab_c[2] = '{-1, -1, 8'h00, 8'hBC, 1'b0, 1'b0, 1'b1};
        tab_c[3] = '{-1, -1, 8'h00, 8'hBC, 1'b0, 1'b0, 1'b1};
        tab_c[4] = '{-1, -1, 8'h00, 8'hBC, 1'b0, 1'b1, 1'b1};
        tab_c[5] = '{-1, -1, 8'h00, 8'hBC, 1'b0, 1'b1, 1'b1};

        din_b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h05, 8'h05, 8'h05};
        rdy_b = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        comma = 8'hBC;
        d11   = 8'h11;

        reset    = 1'b0;
        valid_in = 1'b0;
        data_in  = 8'h00;
        for (int i = 0; i < 3; i++) reset_edge();

        reset = 1'b1;
        foreach (tab_a[i]) run_sym(tab_a[i]);

        // Idle symbol while the producer pushes 01..04 and then stalls on full.
        for (int i = 0; i < 8; i++) begin
            valid_in = 1'b1;
            data_in  = din_b[i];
            edge_step();
            chk("burst_data_out", {7'd0, data_out}, {7'd0, comma[7-i]});
            chk("burst_ready", {7'd0, ready_out}, {7'd0, rdy_b[i]});
        end
        foreach (tab_b[i]) run_sym(tab_b[i]);

        // Buffer three bytes during an idle symbol, then reset at bit 3 of 0x11.
        for (int i = 0; i < 8; i++) begin
            valid_in = (i < 3);
            data_in  = (i == 0) ? 8'h11 : (i == 1) ? 8'h22 : 8'h33;
            edge_step();
            chk("fill_data_out", {7'd0, data_out}, {7'd0, comma[7-i]});
        end
        valid_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            edge_step();
            chk("pre_rst_data_out", {7'd0, data_out}, {7'd0, d11[7-i]});
            chk("pre_rst_data_flag", {7'd0, data_flag}, 8'd1);
        end
        reset_edge();
        reset_edge();
        reset    = 1'b1;
        valid_in = 1'b0;
        foreach (tab_c[i]) run_sym(tab_c[i]);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
